// File: rtl/pixel_writer.sv
// pixel_writer: fragment sink at the end of the rasterizer stream.
// Accepts one fragment at a time, optionally depth-tests it against a 16-bit
// Z-buffer, writes passing fragments to the framebuffer as RGB565 and
// optionally updates the Z-buffer. A full-screen clear fills both buffers.
//
// Ports
//   clk, rst_n                      clock, synchronous active-low reset
//   frag_in/frag_valid/frag_ready   fragment stream (valid/ready)
//   depth_test_en/_lequal/_write_en depth config, sampled at accept
//   zbuf_rd_*                       Z read port, data returns one cycle later
//   zbuf_wr_*                       Z write port, always accepted
//   fb_wr_*                         framebuffer write (valid/ready), RGB565
//   clear_start/clear_color         start a full clear with this color
//   busy                            FSM not idle
//   pass_count/reject_count         fragment statistics (wrap at 2^32)
//
// States
//   IDLE  | waiting for a fragment or a clear request
//   READ  | Z read issued for the latched address
//   CMP   | Z read data valid, depth compare
//   WRITE | framebuffer write held until handshake, optional Z write
//   CLEAR | sweeping all pixels with clear color and far Z

package pixel_writer_pkg;
    typedef logic signed [31:0] fp32_t;

    typedef struct packed {
        logic [15:0] x;
        logic [15:0] y;
        fp32_t       z;
        fp32_t       r;
        fp32_t       g;
        fp32_t       b;
    } fragment_t;
endpackage

module pixel_writer
    import pixel_writer_pkg::*;
#(
    parameter int FB_WIDTH  = 640,
    parameter int FB_HEIGHT = 480,
    parameter int ADDR_W    = 19,
    parameter int FRAC_BITS = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  fragment_t         frag_in,
    input  logic              frag_valid,
    output logic              frag_ready,
    input  logic              depth_test_en,
    input  logic              depth_lequal,
    input  logic              depth_write_en,
    output logic              zbuf_rd_en,
    output logic [ADDR_W-1:0] zbuf_rd_addr,
    input  logic [15:0]       zbuf_rd_data,
    output logic              zbuf_wr_en,
    output logic [ADDR_W-1:0] zbuf_wr_addr,
    output logic [15:0]       zbuf_wr_data,
    output logic              fb_wr_valid,
    input  logic              fb_wr_ready,
    output logic [ADDR_W-1:0] fb_wr_addr,
    output logic [15:0]       fb_wr_data,
    input  logic              clear_start,
    input  logic [15:0]       clear_color,
    output logic              busy,
    output logic [31:0]       pass_count,
    output logic [31:0]       reject_count
);

    localparam int                 NPIX     = FB_WIDTH * FB_HEIGHT;
    localparam logic [ADDR_W-1:0]  LAST_PIX = ADDR_W'(NPIX - 1);
    localparam logic signed [31:0] ONE      = 32'sd1 <<< FRAC_BITS;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        CMP   = 3'd2,
        WRITE = 3'd3,
        CLEAR = 3'd4
    } state_t;

    state_t state_q, state_d;

    logic [ADDR_W-1:0] addr_q;
    logic [15:0]       color_q;
    logic [15:0]       zq_q;
    logic              lequal_q;
    logic              dwe_q;
    logic [15:0]       clr_color_q;
    logic [ADDR_W-1:0] clr_addr_q;
    logic [31:0]       pass_count_q;
    logic [31:0]       reject_count_q;

    logic              accept;
    logic              oob;
    logic              zpass;
    logic [ADDR_W-1:0] addr_d;
    logic [15:0]       zq_d;
    logic [15:0]       color_d;

    // Only some fraction bits of each channel are consumed; this keeps the
    // remaining bits of the fragment visibly accounted for.
    logic unused_frag;
    assign unused_frag = ^frag_in;

    function automatic logic [15:0] quant_z(input logic signed [31:0] v);
        if (v < 0)
            return 16'h0000;
        else if (v >= ONE)
            return 16'hFFFF;
        else
            return v[FRAC_BITS-1 -: 16];
    endfunction

    function automatic logic [4:0] quant5(input logic signed [31:0] v);
        if (v < 0)
            return 5'h00;
        else if (v >= ONE)
            return 5'h1F;
        else
            return v[FRAC_BITS-1 -: 5];
    endfunction

    function automatic logic [5:0] quant6(input logic signed [31:0] v);
        if (v < 0)
            return 6'h00;
        else if (v >= ONE)
            return 6'h3F;
        else
            return v[FRAC_BITS-1 -: 6];
    endfunction

    always_comb begin
        oob     = (32'(frag_in.x) >= 32'(FB_WIDTH)) || (32'(frag_in.y) >= 32'(FB_HEIGHT));
        addr_d  = ADDR_W'(frag_in.y) * ADDR_W'(FB_WIDTH) + ADDR_W'(frag_in.x);
        zq_d    = quant_z(frag_in.z);
        color_d = {quant5(frag_in.r), quant6(frag_in.g), quant5(frag_in.b)};
    end

    // Outputs are gated by rst_n so nothing is issued during a reset cycle,
    // making an abort mid-WRITE or mid-CLEAR take effect immediately.
    always_comb begin
        state_d      = state_q;
        frag_ready   = 1'b0;
        accept       = 1'b0;
        zpass        = 1'b0;
        zbuf_rd_en   = 1'b0;
        zbuf_rd_addr = '0;
        zbuf_wr_en   = 1'b0;
        zbuf_wr_addr = '0;
        zbuf_wr_data = 16'h0000;
        fb_wr_valid  = 1'b0;
        fb_wr_addr   = '0;
        fb_wr_data   = 16'h0000;
        if (rst_n) begin
            case (state_q)
                IDLE: begin
                    frag_ready = !clear_start;
                    if (clear_start) begin
                        state_d = CLEAR;
                    end else if (frag_valid) begin
                        accept = 1'b1;
                        if (!oob)
                            state_d = depth_test_en ? READ : WRITE;
                    end
                end
                READ: begin
                    zbuf_rd_en   = 1'b1;
                    zbuf_rd_addr = addr_q;
                    state_d      = CMP;
                end
                CMP: begin
                    zpass   = lequal_q ? (zq_q <= zbuf_rd_data) : (zq_q < zbuf_rd_data);
                    state_d = zpass ? WRITE : IDLE;
                end
                WRITE: begin
                    fb_wr_valid = 1'b1;
                    fb_wr_addr  = addr_q;
                    fb_wr_data  = color_q;
                    if (fb_wr_ready) begin
                        zbuf_wr_en   = dwe_q;
                        zbuf_wr_addr = addr_q;
                        zbuf_wr_data = zq_q;
                        state_d      = IDLE;
                    end
                end
                CLEAR: begin
                    fb_wr_valid = 1'b1;
                    fb_wr_addr  = clr_addr_q;
                    fb_wr_data  = clr_color_q;
                    if (fb_wr_ready) begin
                        zbuf_wr_en   = 1'b1;
                        zbuf_wr_addr = clr_addr_q;
                        zbuf_wr_data = 16'hFFFF;
                        if (clr_addr_q == LAST_PIX)
                            state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_q      <= '0;
            color_q     <= 16'h0000;
            zq_q        <= 16'h0000;
            lequal_q    <= 1'b0;
            dwe_q       <= 1'b0;
            clr_color_q <= 16'h0000;
            clr_addr_q  <= '0;
        end else begin
            if (accept) begin
                addr_q   <= addr_d;
                color_q  <= color_d;
                zq_q     <= zq_d;
                lequal_q <= depth_lequal;
                dwe_q    <= depth_write_en;
            end
            if (state_q == IDLE && clear_start) begin
                clr_color_q <= clear_color;
                clr_addr_q  <= '0;
            end else if (state_q == CLEAR && fb_wr_ready) begin
                clr_addr_q <= (clr_addr_q == LAST_PIX) ? '0 : clr_addr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pass_count_q   <= 32'd0;
            reject_count_q <= 32'd0;
        end else begin
            if ((accept && oob) || (state_q == CMP && !zpass))
                reject_count_q <= reject_count_q + 32'd1;
            if (state_q == WRITE && fb_wr_ready)
                pass_count_q <= pass_count_q + 32'd1;
        end
    end

    assign busy         = (state_q != IDLE);
    assign pass_count   = pass_count_q;
    assign reject_count = reject_count_q;

endmodule
